mesm6_timer_irq: RTL

Interrupt-source block for the MESM-6 core: a programmable prescaled interval timer plus a synchronised, edge-detected external interrupt line. It sits directly upstream of the interrupt controller and drives its 2-bit synchronous request input (`irq[0]` = timer expiry, `irq[1]` = external event) with single-cycle pulses. It is register-mapped on the same 48-bit peripheral bus, using the same read/write/done handshake as the other peripherals.

---
 rtl/mesm6_timer_irq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mesm6_timer_irq.sv
// MESM-6 interrupt sources: prescaled interval timer and edge-detected
// external line, register-mapped on the 48-bit peripheral bus.
module mesm6_timer_irq #(
  parameter int CNT_W       = 32,
  parameter int PRE_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq,
  input  logic [14:0] tmr_addr,
  input  logic        tmr_read,
  input  logic        tmr_write,
  input  logic [47:0] tmr_wdata,
  output logic [47:0] tmr_rdata,
  output logic        tmr_done,
  output logic [1:0]  irq
);

  localparam logic [2:0] A_CNT    = 3'o0;
  localparam logic [2:0] A_PERIOD = 3'o1;
  localparam logic [2:0] A_CTRL   = 3'o2;
  localparam logic [2:0] A_STATUS = 3'o3;
  localparam logic [2:0] A_PRE    = 3'o4;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [3:0]             ctrl_q, ctrl_d;
  logic [1:0]             status_q, status_d;
  logic [PRE_W-1:0]       prescale_q, prescale_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [1:0]             irq_q, irq_d;
  logic                   done_q, done_d;

  logic [2:0] addr;
  logic       wr_cnt, wr_period, wr_ctrl;
  logic       wr_status, wr_pre;
  logic       en, auto_rl, xen, xpol;
  logic       tick_due, en_kill, tick, expire;
  logic       x_new, x_rise, x_fall, xevt;
  logic [1:0] clr;
  logic       unused_ok;

  assign unused_ok = ^{tmr_addr, tmr_wdata};

  assign addr      = tmr_addr[2:0];
  assign wr_cnt    = tmr_write && (addr == A_CNT);
  assign wr_period = tmr_write && (addr == A_PERIOD);
  assign wr_ctrl   = tmr_write && (addr == A_CTRL);
  assign wr_status = tmr_write && (addr == A_STATUS);
  assign wr_pre    = tmr_write && (addr == A_PRE);

  assign en      = ctrl_q[0];
  assign auto_rl = ctrl_q[1];
  assign xen     = ctrl_q[2];
  assign xpol    = ctrl_q[3];

  // A CNT write or an EN-clearing CTRL write suppresses a due tick.
  always_comb begin
    tick_due = en && (pre_q == prescale_q);
    en_kill  = wr_ctrl && !tmr_wdata[0];
    tick     = tick_due && !wr_cnt && !en_kill;
    expire   = tick && (cnt_q == CNT_W'(1));
  end

  always_comb begin
    pre_d = pre_q;
    if (!en || wr_cnt || wr_pre || wr_ctrl) begin
      pre_d = '0;
    end else if (pre_q == prescale_q) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt) begin
      cnt_d = tmr_wdata[CNT_W-1:0];
    end else if (tick) begin
      if (cnt_q > CNT_W'(1)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (expire) begin
        cnt_d = auto_rl ? period_q : '0;
      end
    end
  end

  always_comb begin
    period_d   = wr_period ? tmr_wdata[CNT_W-1:0] : period_q;
    prescale_d = wr_pre ? tmr_wdata[PRE_W-1:0] : prescale_q;
    ctrl_d     = wr_ctrl ? tmr_wdata[3:0] : ctrl_q;
    if (expire && !auto_rl) begin
      ctrl_d[0] = 1'b0;
    end
  end

  // History flop keeps tracking even while XEN is off.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ext_irq};
    x_new  = sync_q[SYNC_STAGES-1];
    hist_d = x_new;
    x_rise = x_new && !hist_q;
    x_fall = !x_new && hist_q;
    xevt   = xen && (xpol ? x_fall : x_rise);
  end

  // Set beats clear on STATUS.
  always_comb begin
    clr      = wr_status ? tmr_wdata[1:0] : 2'b00;
    status_d = (status_q & ~clr) | {xevt, expire};
    irq_d    = {xevt, expire};
    done_d   = tmr_read || tmr_write;
  end

  always_comb begin
    tmr_rdata = '0;
    unique case (addr)
      A_CNT:    tmr_rdata = 48'(cnt_q);
      A_PERIOD: tmr_rdata = 48'(period_q);
      A_CTRL:   tmr_rdata = 48'(ctrl_q);
      A_STATUS: tmr_rdata = 48'(status_q);
      A_PRE:    tmr_rdata = 48'(prescale_q);
      default:  tmr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      period_q   <= '0;
      ctrl_q     <= '0;
      status_q   <= '0;
      prescale_q <= '0;
      pre_q      <= '0;
      sync_q     <= '0;
      hist_q     <= 1'b0;
      irq_q      <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      prescale_q <= prescale_d;
      pre_q      <= pre_d;
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      irq_q      <= irq_d;
      done_q     <= done_d;
    end
  end

  assign irq      = irq_q;
  assign tmr_done = done_q;

endmodule
